// File: rtl/tl_pkg.sv
// Shared types and constants for the two-road traffic light controller.
package tl_pkg;

    // Phase encoding; the numeric values are visible on the debug phase output.
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED_A = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED_B = 3'd5
    } phase_t;

    // Lamp encoding {red, yellow, green}, one-hot.
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Shared phase timer width and its saturation value.
    localparam int         TIMER_W   = 6;
    localparam logic [5:0] TIMER_MAX = 6'd63;

endpackage

// File: rtl/phase_timer.sv
// Cycles-in-phase counter: clears synchronously, otherwise counts up and
// holds at its maximum so a long idle phase never wraps back to a small value.
module phase_timer
    import tl_pkg::*;
(
    input  logic               clk,
    input  logic               clear,
    output logic [TIMER_W-1:0] count
);

    // Count up each cycle, saturating at TIMER_MAX; clear has priority.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (count != TIMER_MAX) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_light_controller.sv
// Six-phase Moore sequencer for a main road (NS) and a side road (EW) with a
// side-road car sensor and a latched pedestrian request.
module traffic_light_controller
    import tl_pkg::*;
#(
    parameter int NS_MIN   = 8,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2,
    parameter int EW_MIN   = 4,
    parameter int EW_MAX   = 10,
    parameter int WALK_T   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ew_car,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [2:0] phase
);

    // Timer values on the last cycle of each timed window (t counts from 0).
    localparam logic [TIMER_W-1:0] NS_LAST     = TIMER_W'(NS_MIN - 1);
    localparam logic [TIMER_W-1:0] YEL_LAST    = TIMER_W'(YELLOW_T - 1);
    localparam logic [TIMER_W-1:0] ALLRED_LAST = TIMER_W'(ALLRED_T - 1);
    localparam logic [TIMER_W-1:0] EW_MIN_LAST = TIMER_W'(EW_MIN - 1);
    localparam logic [TIMER_W-1:0] EW_MAX_LAST = TIMER_W'(EW_MAX - 1);
    localparam logic [TIMER_W-1:0] WALK_LAST   = TIMER_W'(WALK_T - 1);

    phase_t               state_q;
    phase_t               state_d;
    logic [TIMER_W-1:0]   timer_q;
    logic                 phase_change;
    logic                 enter_ew;
    logic                 leave_ew;
    logic                 ped_pending;
    logic                 walk_active;

    // The timer restarts on every phase change so t is always "cycles in this phase".
    phase_timer u_timer (
        .clk   (clk),
        .clear (reset | phase_change),
        .count (timer_q)
    );

    // Next-phase logic: each phase advances only to its fixed successor.
    always_comb begin
        state_d = state_q;
        case (state_q)
            NS_GREEN: begin
                if (timer_q >= NS_LAST && (ew_car || ped_pending))
                    state_d = NS_YELLOW;
            end
            NS_YELLOW: begin
                if (timer_q == YEL_LAST) state_d = ALL_RED_A;
            end
            ALL_RED_A: begin
                if (timer_q == ALLRED_LAST) state_d = EW_GREEN;
            end
            EW_GREEN: begin
                // Hard cap at EW_MAX; otherwise leave early once the side road
                // is empty and any granted walk has had its minimum time.
                if (timer_q == EW_MAX_LAST ||
                    (timer_q >= EW_MIN_LAST && !ew_car &&
                     (!walk_active || timer_q >= WALK_LAST)))
                    state_d = EW_YELLOW;
            end
            EW_YELLOW: begin
                if (timer_q == YEL_LAST) state_d = ALL_RED_B;
            end
            ALL_RED_B: begin
                if (timer_q == ALLRED_LAST) state_d = NS_GREEN;
            end
            default: state_d = NS_GREEN;
        endcase
    end

    assign phase_change = (state_d != state_q);
    assign enter_ew     = (state_q == ALL_RED_A) && (state_d == EW_GREEN);
    assign leave_ew     = (state_q == EW_GREEN)  && (state_d != EW_GREEN);

    // Phase register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= NS_GREEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Pedestrian latch and walk grant; a press on the EW entry edge is
    // absorbed by that green rather than queued for the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            ped_pending <= 1'b0;
            walk_active <= 1'b0;
        end else if (enter_ew) begin
            ped_pending <= 1'b0;
            walk_active <= ped_pending;
        end else begin
            if (ped_req) ped_pending <= 1'b1;
            if (leave_ew) walk_active <= 1'b0;
        end
    end

    // Lamp decode straight from the phase register (Moore outputs).
    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        case (state_q)
            NS_GREEN:  ns_light = LAMP_GRN;
            NS_YELLOW: ns_light = LAMP_YEL;
            EW_GREEN:  ew_light = LAMP_GRN;
            EW_YELLOW: ew_light = LAMP_YEL;
            default: begin
                ns_light = LAMP_RED;
                ew_light = LAMP_RED;
            end
        endcase
    end

    assign walk  = walk_active;
    assign phase = state_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Scoreboard bench for traffic_light_controller: a cycle model predicts the
// outputs for each driven cycle, plus directed phase-length checks.
module tb_traffic_light_controller;

    localparam int NS_MIN   = 8;
    localparam int YELLOW_T = 3;
    localparam int ALLRED_T = 2;
    localparam int EW_MIN   = 4;
    localparam int EW_MAX   = 10;
    localparam int WALK_T   = 6;

    logic       clk;
    logic       reset;
    logic       ew_car;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic [2:0] phase;

    traffic_light_controller #(
        .NS_MIN   (NS_MIN),
        .YELLOW_T (YELLOW_T),
        .ALLRED_T (ALLRED_T),
        .EW_MIN   (EW_MIN),
        .EW_MAX   (EW_MAX),
        .WALK_T   (WALK_T)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ew_car   (ew_car),
        .ped_req  (ped_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .walk     (walk),
        .phase    (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int m_state = 0;
    int m_cnt   = 0;
    bit m_ped   = 0;
    bit m_walk  = 0;

    logic [9:0] sb[$];

    // Run-length record of observed phases since the last reset
    int run_ph[$];
    int run_len[$];
    int cur_ph;
    int cur_len;

    task automatic model_step(input bit car, input bit ped, input bit rst);
        bit ex;
        ex = 0;
        if (rst) begin
            m_state = 0; m_cnt = 0; m_ped = 0; m_walk = 0;
            return;
        end
        case (m_state)
            0: ex = (m_cnt >= NS_MIN - 1) && (car || m_ped);
            1, 4: ex = (m_cnt == YELLOW_T - 1);
            2, 5: ex = (m_cnt == ALLRED_T - 1);
            3: ex = (m_cnt == EW_MAX - 1) ||
                    ((m_cnt >= EW_MIN - 1) && !car && (!m_walk || m_cnt >= WALK_T - 1));
            default: ex = 1;
        endcase
        if (ex && m_state == 2) begin
            m_walk = m_ped;
            m_ped  = 0;
        end else begin
            if (ped) m_ped = 1;
            if (ex && m_state == 3) m_walk = 0;
        end
        if (ex) begin
            m_state = (m_state == 5) ? 0 : m_state + 1;
            m_cnt   = 0;
        end else if (m_cnt < 63) begin
            m_cnt = m_cnt + 1;
        end
    endtask

    function automatic logic [5:0] lamps(input int st);
        case (st)
            0: lamps = {3'b001, 3'b100};
            1: lamps = {3'b010, 3'b100};
            3: lamps = {3'b100, 3'b001};
            4: lamps = {3'b100, 3'b010};
            default: lamps = {3'b100, 3'b100};
        endcase
    endfunction

    task automatic step(input bit car, input bit ped, input bit rst);
        logic [9:0] e;
        logic [9:0] g;
        ew_car  = car;
        ped_req = ped;
        reset   = rst;
        model_step(car, ped, rst);
        sb.push_back({3'(m_state), lamps(m_state), m_walk});
        @(posedge clk);
        #1;
        g = {phase, ns_light, ew_light, walk};
        e = sb.pop_front();
        chk("outputs", g, e);
        chk("timer", 32'(dut.timer_q), 32'(m_cnt));
        chk("lamp_excl", 32'(ns_light[2] == 1'b0 && ew_light[2] == 1'b0), 0);
        chk("ns_onehot", 32'($onehot(ns_light)), 1);
        chk("ew_onehot", 32'($onehot(ew_light)), 1);
        if (rst) begin
            run_ph.delete();
            run_len.delete();
            cur_ph  = int'(phase);
            cur_len = 1;
        end else if (int'(phase) == cur_ph) begin
            cur_len++;
        end else begin
            run_ph.push_back(cur_ph);
            run_len.push_back(cur_len);
            cur_ph  = int'(phase);
            cur_len = 1;
        end
    endtask

    task automatic chk_run(input string tag, input int k, input int ph, input int len);
        int gp;
        int gl;
        gp = (k < run_ph.size()) ? run_ph[k] : -1;
        gl = (k < run_len.size()) ? run_len[k] : -1;
        chk({tag, "_phase"}, 32'(gp), 32'(ph));
        chk({tag, "_len"}, 32'(gl), 32'(len));
    endtask

    int exp_len[12] = '{8, 3, 2, 10, 3, 2, 8, 3, 2, 10, 3, 2};
    int ped_len[10] = '{8, 3, 2, 6, 3, 2, 8, 3, 2, 6};

    initial begin
        int walk_cycles;
        bit seen_ew;
        reset   = 1'b1;
        ew_car  = 1'b0;
        ped_req = 1'b0;

        // Reset and idle hold
        step(0, 0, 1);
        step(0, 0, 1);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_ns", 32'(ns_light), 32'h1);
        chk("rst_ew", 32'(ew_light), 32'h4);
        chk("rst_walk", 32'(walk), 0);
        chk("rst_ped", 32'(dut.ped_pending), 0);
        chk("rst_timer", 32'(dut.timer_q), 0);
        for (int i = 1; i <= 200; i++) begin
            step(0, 0, 0);
            if (i == 63) chk("idle_timer63", 32'(dut.timer_q), 63);
        end
        chk("idle_phase", 32'(phase), 0);
        chk("idle_timer", 32'(dut.timer_q), 63);

        // Continuous EW demand: 28-cycle period
        step(0, 0, 1);
        for (int i = 1; i <= 60; i++) step(1, 0, 0);
        for (int k = 0; k < 12; k++) chk_run("cont", k, k % 6, exp_len[k]);

        // Single-cycle car pulse 20 cycles after reset
        step(0, 0, 1);
        for (int i = 1; i <= 40; i++) step(i == 20, 0, 0);
        chk_run("pulse_nsg", 0, 0, 20);
        chk_run("pulse_nsy", 1, 1, 3);
        chk_run("pulse_ara", 2, 2, 2);
        chk_run("pulse_ewg", 3, 3, 4);

        // Pedestrian request, then a second press during the walk phase
        step(0, 0, 1);
        walk_cycles = 0;
        seen_ew = 0;
        for (int i = 1; i <= 59; i++) begin
            step(0, (i == 2) || (i == 15), 0);
            if (walk) walk_cycles++;
            if (phase == 3'd3 && !seen_ew) begin
                seen_ew = 1;
                chk("ped_cleared", 32'(dut.ped_pending), 0);
                chk("walk_on_entry", 32'(walk), 1);
            end
        end
        for (int k = 0; k < 10; k++) chk_run("ped", k, k % 6, ped_len[k]);
        chk("walk_cycles", 32'(walk_cycles), 12);

        // Reset during a walk-granted EW green
        step(0, 0, 1);
        for (int i = 1; i <= 15; i++) step(0, i == 2, 0);
        chk("pre_rst_phase", 32'(phase), 3);
        chk("pre_rst_walk", 32'(walk), 1);
        step(0, 0, 1);
        chk("mid_rst_phase", 32'(phase), 0);
        chk("mid_rst_ns", 32'(ns_light), 32'h1);
        chk("mid_rst_ew", 32'(ew_light), 32'h4);
        chk("mid_rst_walk", 32'(walk), 0);
        for (int i = 1; i <= 20; i++) step(0, 0, 0);
        chk("post_rst_hold", 32'(phase), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
